mcp3008_responder: RTL
======================

MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

Interface
Parameters (name, default, meaning):
REQ-001 SYNC_STAGES, 2, synchronizer depth on ad_clk/cs/din; legal values are 2 to 4.
Ports (name, direction, width, meaning):
REQ-002 clk  in  1  system clock, at least 8x the ad_clk frequency.
REQ-003 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 ad_clk  in  1  SPI serial clock from the ADC master; asynchronous to clk.
REQ-005 cs  in  1  chip select, active low, asynchronous.
REQ-006 din  in  1  master-to-responder serial data.
REQ-007 dout  out  1  responder-to-master serial data.
REQ-008 dout_oe  out  1  high while dout is actively driven.
REQ-009 ch_data  in  80  eight 10-bit channel values; ch n = bits [10n+9:10n].
REQ-010 conv_done  out  1  one-clk pulse when B0 is driven.
REQ-011 last_chan  out  3  D2..D0 of the last completed frame.
REQ-012 last_sgl  out  1  SGL/DIFF bit of the last completed frame.
REQ-013 frame_count  out  8  count of completed frames; wraps 255 to 0.

Function
REQ-014 ad_clk, cs and din each pass through SYNC_STAGES flops; edges are detected against one further registered copy; all logic runs on clk.
REQ-015 A sync rise or sync fall event is a single-clk strobe; dout updates 1 clk after the fall strobe, i.e. SYNC_STAGES+1 clks after the pin edge.
REQ-016 States: IDLE, WAIT_START, HEADER, SAMPLE, NULLB, DATA, TRAIL.
REQ-017 IDLE: enter WAIT_START when synced cs is low.
REQ-018 WAIT_START: on a rise with din=1 go to HEADER; on a rise with din=0 stay (leading zeros are ignored).
REQ-019 HEADER: capture din MSB-first on 4 rises into cfg[3:0] = {SGL, D2, D1, D0}.
REQ-020 On the 4th header rise, latch the result and enter SAMPLE.
REQ-021 Single-ended result (SGL=1): ch_data[chan], where chan = {D2,D1,D0}.
REQ-022 Differential result (SGL=0): IN+ = ch[{D2,D1,D0}], IN- = ch[{D2,D1,~D0}]; result = IN+ - IN-, clamped to 0 when negative; 10-bit unsigned.
REQ-023 After latching, ch_data changes do not affect the frame in progress.
REQ-024 SAMPLE: ignore one full sclk period (next rise); on the following fall enter NULLB, drive dout=0 and dout_oe=1.
REQ-025 NULLB/DATA: each subsequent fall drives the next result bit, B9 first and B0 last.
REQ-026 In the cycle B0 is driven: pulse conv_done, update last_chan and last_sgl, increment frame_count.
REQ-027 After B0, the next fall enters TRAIL: dout=0, dout_oe=1, held until cs rises.
REQ-028 From any non-IDLE state, synced cs high returns to IDLE on that clk: dout=0, dout_oe=0, no conv_done.
REQ-029 A cs abort leaves last_chan, last_sgl and frame_count unchanged.
REQ-030 dout=0 whenever dout_oe=0.
REQ-031 Rise and fall events while in IDLE are ignored.
REQ-032 A cs rise coinciding with a sclk event: the cs abort has priority.

Reset
REQ-033 While rst_n is low, immediately: state=IDLE, dout=0, dout_oe=0, conv_done=0, last_chan=0, last_sgl=0, frame_count=0, synchronizer flops=1 for cs and 0 for ad_clk and din.
REQ-034 Reset asserted mid-frame discards the frame; the first frame after release behaves per REQ-017 to REQ-027.

Verification
REQ-035 ch0=0x2A5; cs low; din 1,1,0,0,0 -> after the SAMPLE period, dout on falls reads 0,1,0,1,0,1,0,0,1,0,1; one conv_done pulse; last_chan=0, last_sgl=1, frame_count=1.
REQ-036 Three leading 0 bits before the start bit, ch5=0x3FF, header 1,1,0,1 -> null bit then ten 1s; last_chan=5.
REQ-037 ch0=100, ch1=300: diff header D=001 -> result 200 (0x0C8); diff header D=000 -> result 0 (clamp).
REQ-038 cs raised after 2 data bits -> dout_oe=0 within SYNC_STAGES+2 clks; no conv_done; frame_count unchanged; next frame correct.
REQ-039 rst_n pulsed low during DATA -> outputs at reset values within the same clk; next frame returns the correct value with frame_count=1.
REQ-040 ch_data changed during DATA -> the old value is shifted out; 256 completed frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder: synchronises the master's SCLK/CS/DIN into clk,
// decodes the start/config header and shifts back a null bit plus a 10-bit result.
module mcp3008_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad_clk,
  input  logic        cs,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [79:0] ch_data,
  output logic        conv_done,
  output logic [2:0]  last_chan,
  output logic        last_sgl,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    HEADER,
    SAMPLE,
    NULLB,
    DATA,
    TRAIL
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   sclk_q;
  logic                   sclk_s, cs_s, din_s;
  logic                   rise, fall;

  logic [3:0] cfg, cfg_n, cfg_new;
  logic [1:0] hdr_cnt, hdr_cnt_n;
  logic       seen_rise, seen_rise_n;
  logic [9:0] shreg, shreg_n;
  logic [3:0] bits_left, bits_left_n;
  logic       dout_n, dout_oe_n, conv_done_n;
  logic [2:0] last_chan_n;
  logic       last_sgl_n;
  logic [7:0] frame_count_n;
  logic       abort;

  logic [9:0]  ch [8];
  logic [9:0]  plus, minus, result;
  logic [10:0] diff;

  // CS synchroniser resets high so a held-low pin is seen as a fresh select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ad_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;
  assign fall   = ~sclk_s & sclk_q;
  assign abort  = (state != IDLE) && cs_s;

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      ch[i] = ch_data[10*i +: 10];
    end
  end

  // Result is computed from the header including the bit arriving on this rise.
  assign cfg_new = {cfg[2:0], din_s};
  assign plus    = ch[cfg_new[2:0]];
  assign minus   = ch[{cfg_new[2:1], ~cfg_new[0]}];
  assign diff    = {1'b0, plus} - {1'b0, minus};
  assign result  = cfg_new[3] ? plus : (diff[10] ? '0 : diff[9:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg         <= '0;
      hdr_cnt     <= '0;
      seen_rise   <= 1'b0;
      shreg       <= '0;
      bits_left   <= '0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_done   <= 1'b0;
      last_chan   <= '0;
      last_sgl    <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      cfg         <= cfg_n;
      hdr_cnt     <= hdr_cnt_n;
      seen_rise   <= seen_rise_n;
      shreg       <= shreg_n;
      bits_left   <= bits_left_n;
      dout        <= dout_n;
      dout_oe     <= dout_oe_n;
      conv_done   <= conv_done_n;
      last_chan   <= last_chan_n;
      last_sgl    <= last_sgl_n;
      frame_count <= frame_count_n;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (!cs_s) state_next = WAIT_START;
        WAIT_START: if (rise && din_s) state_next = HEADER;
        HEADER:     if (rise && hdr_cnt == 2'd3) state_next = SAMPLE;
        SAMPLE:     if (fall && seen_rise) state_next = NULLB;
        NULLB:      if (fall) state_next = DATA;
        DATA:       if (fall && bits_left == 4'd0) state_next = TRAIL;
        TRAIL:      state_next = TRAIL;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_n         = cfg;
    hdr_cnt_n     = hdr_cnt;
    seen_rise_n   = seen_rise;
    shreg_n       = shreg;
    bits_left_n   = bits_left;
    dout_n        = dout;
    dout_oe_n     = dout_oe;
    conv_done_n   = 1'b0;
    last_chan_n   = last_chan;
    last_sgl_n    = last_sgl;
    frame_count_n = frame_count;
    if (abort) begin
      dout_n    = 1'b0;
      dout_oe_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_n    = 1'b0;
          dout_oe_n = 1'b0;
        end
        WAIT_START: begin
          if (rise && din_s) hdr_cnt_n = 2'd0;
        end
        HEADER: begin
          if (rise) begin
            cfg_n     = cfg_new;
            hdr_cnt_n = hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              shreg_n     = result;
              seen_rise_n = 1'b0;
            end
          end
        end
        SAMPLE: begin
          if (rise) begin
            seen_rise_n = 1'b1;
          end else if (fall && seen_rise) begin
            dout_n    = 1'b0;
            dout_oe_n = 1'b1;
          end
        end
        NULLB: begin
          if (fall) begin
            dout_n      = shreg[9];
            shreg_n     = {shreg[8:0], 1'b0};
            bits_left_n = 4'd9;
          end
        end
        DATA: begin
          if (fall) begin
            if (bits_left == 4'd0) begin
              dout_n = 1'b0;
            end else begin
              dout_n      = shreg[9];
              shreg_n     = {shreg[8:0], 1'b0};
              bits_left_n = bits_left - 4'd1;
              if (bits_left == 4'd1) begin
                conv_done_n   = 1'b1;
                last_chan_n   = cfg[2:0];
                last_sgl_n    = cfg[3];
                frame_count_n = frame_count + 8'd1;
              end
            end
          end
        end
        TRAIL: begin
          dout_n    = 1'b0;
          dout_oe_n = 1'b1;
        end
        default: begin
          dout_n    = 1'b0;
          dout_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule
